// File: rtl/stopwatch_core.sv
// Stopwatch counting elapsed nanoseconds with run/stop, lap freeze, clear and saturation.
// Buttons are pre-debounced levels; a one-register edge detector turns each into a rise pulse.
module stopwatch_core #(
  parameter int unsigned NS_PER_CLK = 10,
  parameter logic [38:0] MAX_NS     = 39'd549755813880
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  output logic [38:0] time_ns_o,
  output logic        running_o,
  output logic        lap_active_o,
  output logic        saturated_o
);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StSat} state_e;

  localparam logic [39:0] StepW = 40'(NS_PER_CLK);
  localparam logic [39:0] MaxW  = {1'b0, MAX_NS};

  state_e      state_q, state_d;
  logic [38:0] count_q, count_d;
  logic [38:0] lap_q, lap_d;
  logic        lap_active_q, lap_active_d;
  logic        ss_prev_q, lap_prev_q, clr_prev_q;
  logic [38:0] time_q;
  logic        running_q, saturated_q;

  logic        ss_rise, lap_rise, clr_rise;
  logic [39:0] count_sum;

  assign ss_rise   = start_stop_i & ~ss_prev_q;
  assign lap_rise  = lap_i & ~lap_prev_q;
  assign clr_rise  = clear_i & ~clr_prev_q;
  // One extra bit so the saturation compare cannot wrap near 2^39.
  assign count_sum = {1'b0, count_q} + StepW;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;

    if (clr_rise) begin
      state_d      = StIdle;
      count_d      = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
    end else if (ss_rise) begin
      // Any lap rise on this edge is dropped; the toggle edge never increments.
      case (state_q)
        StIdle, StStop: state_d = StRun;
        StRun:          state_d = StStop;
        default:        state_d = state_q;
      endcase
    end else begin
      if (state_q == StRun) begin
        if (count_sum >= MaxW) begin
          count_d = MAX_NS;
          state_d = StSat;
        end else begin
          count_d = count_sum[38:0];
        end
      end
      if (lap_rise) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q == StRun || state_q == StStop) begin
          lap_d        = count_q;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // Edge-detect history tracks the levels even in reset, so a held button makes no rise.
    ss_prev_q  <= start_stop_i;
    lap_prev_q <= lap_i;
    clr_prev_q <= clear_i;
    if (rst_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      time_q       <= '0;
      running_q    <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      time_q       <= lap_active_d ? lap_d : count_d;
      running_q    <= (state_d == StRun);
      saturated_q  <= (state_d == StSat);
    end
  end

  assign time_ns_o    = time_q;
  assign running_o    = running_q;
  assign lap_active_o = lap_active_q;
  assign saturated_o  = saturated_q;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter NS_PER_CLK, default 10: nanoseconds added per clock while running (100 MHz clk).
REQ-002 Parameter MAX_NS, default 549755813880: saturation limit; a multiple of NS_PER_CLK and below 2^39.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous reset, active high.
REQ-005 start_stop  input  1  debounced, synchronised level; each rising edge toggles run/stop.
REQ-006 lap  input  1  debounced, synchronised level; each rising edge toggles the lap freeze.
REQ-007 clear  input  1  debounced, synchronised level; a rising edge zeroes the stopwatch.
REQ-008 time_ns  output  39  display time in ns, unsigned binary, registered; feeds the downstream time_conversion input.
REQ-009 running  output  1  high while in state RUN.
REQ-010 lap_active  output  1  high while time_ns is frozen at a lap value.
REQ-011 saturated  output  1  high while in state SAT.

Function
REQ-012 Edge detect: one prev register per button; rise = level AND NOT prev; prev loads level every cycle.
REQ-013 States: IDLE (count 0, stopped), RUN, STOP (count held, nonzero allowed), SAT (count = MAX_NS).
REQ-014 Internal count register is 39 bits; time_ns = lap_reg when lap_active, else count.
REQ-015 In RUN, count increments by NS_PER_CLK on every clock edge.
REQ-016 In IDLE, STOP and SAT, count holds.
REQ-017 Entering RUN is not itself an increment: the edge that enters RUN leaves count unchanged; after k more edges in RUN, count rises by k*NS_PER_CLK.
REQ-018 start_stop rise in IDLE or STOP goes to RUN.
REQ-019 start_stop rise in RUN goes to STOP; count keeps its pre-edge value.
REQ-020 start_stop rise in SAT is ignored.
REQ-021 In RUN, if count + NS_PER_CLK >= MAX_NS, count loads MAX_NS and the state becomes SAT on that edge.
REQ-022 count never exceeds MAX_NS and never wraps.
REQ-023 clear rise in any state: count = 0, lap_reg = 0, lap_active = 0, state = IDLE, all on the same edge.
REQ-024 lap rise with lap_active = 0 in RUN or STOP: lap_reg loads count's pre-edge value and lap_active goes to 1.
REQ-025 lap rise with lap_active = 1, in any state: lap_active goes to 0, so time_ns follows the live count from the next cycle.
REQ-026 lap rise with lap_active = 0 in IDLE or SAT is ignored.
REQ-027 Counting continues underneath a lap freeze.
REQ-028 Simultaneous rises are resolved clear > start_stop > lap: only the highest-priority rise acts; lower ones are discarded, not queued.
REQ-029 Outputs are registered and change only on clk edges; the single-cycle latency from input level to output effect is fixed as the edge-detect register.

Reset
REQ-030 While rst = 1: state = IDLE, count = 0, lap_reg = 0, lap_active = 0, running = 0, saturated = 0, time_ns = 0.
REQ-031 While rst = 1, each prev register loads its current input level, so a button held through reset release produces no rise.
REQ-032 rst has priority over every button.
REQ-033 rst asserted mid-RUN takes effect at the next clock edge, with no partial increment.

Verification
REQ-034 Basic run: reset, start_stop rise, 100 cycles, start_stop rise -> time_ns = 1000, running = 0; count holds for 50 further cycles.
REQ-035 Lap: while running at count 5000, lap rise -> time_ns stays 5000 while count advances; after 20 cycles, lap rise -> time_ns = 5200 on the following cycle.
REQ-036 Saturation: with MAX_NS = 100, start and run 15 cycles -> time_ns = 100, saturated = 1, running = 0; a start_stop rise is ignored; a clear rise -> time_ns = 0 and state IDLE.
REQ-037 Priority: clear, start_stop and lap rise on the same cycle during RUN at count 300 -> count = 0, IDLE, lap_active = 0.
REQ-038 Reset hold: start_stop held high through rst release -> no run; one start_stop low-high cycle afterwards -> running = 1.
REQ-039 Mid-run reset: rst pulsed for 1 cycle at count 770 -> next edge time_ns = 0, running = 0, saturated = 0.
